uart_fifo: RTL and testbench
============================

# uart_fifo

Byte FIFO placed between the UART receiver and the operand-collecting receive interface. It absorbs bursts of received bytes, so a byte completed by the receiver while the interface is busy is not lost. It presents the oldest stored byte in first-word-fall-through form with a `wr`/`rd`/`empty` handshake. The same block, instanced a second time, can buffer result bytes ahead of the transmitter.

## Interface
- `DBIT`, default 8: data word width in bits.
- `ADDR_W`, default 2: address width; depth = 2**ADDR_W (default 4 entries).

Clock and reset: one clock; reset is synchronous and active-low.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr`  in  1  push request; connected to the receiver's `rx_done_tick`; one-cycle pulse per byte.
- `w_data`  in  DBIT  byte to push; sampled on the edge where `wr`=1.
- `rd`  in  1  pop request from the consumer; one-cycle pulse per byte.
- `r_data`  out  DBIT  head-of-queue byte; valid while `empty`=0; forced to 0 while `empty`=1.
- `empty`  out  1  queue holds no bytes.
- `full`  out  1  queue holds 2**ADDR_W bytes.
- `count`  out  ADDR_W+1  number of stored bytes, 0 to 2**ADDR_W.
- `overflow`  out  1  sticky flag: at least one push was dropped since reset.

## Operation
- Storage:
  - Register array of 2**ADDR_W × DBIT.
  - Write pointer and read pointer, each ADDR_W bits, both wrapping modulo depth.
  - `count` register of ADDR_W+1 bits.
- `empty` = (`count`==0) and `full` = (`count`==2**ADDR_W). Both are derived from the registered `count`, so neither flag depends on `wr` or `rd` in the same cycle.
- Per-edge decision on (`wr`, `rd`):
  - 0,0: hold.
  - 1,0, not full: write `w_data` at the write pointer; write pointer +1; `count` +1.
  - 1,0, full: drop the byte; set `overflow`; pointers and `count` unchanged.
  - 0,1, not empty: read pointer +1; `count` −1.
  - 0,1, empty: ignored; no state change; no flag.
  - 1,1, empty: push only. `rd` is ignored; `count` becomes 1.
  - 1,1, full: pop and push together. Both pointers +1; `count` stays at full; no overflow.
  - 1,1, otherwise: pop and push together. Both pointers +1; `count` unchanged.
- `r_data` = array[read pointer] when `empty`=0, else 0. This is a combinational read, so the head byte is visible without a `rd` (first-word fall-through).
- `overflow` clears only on reset.
- Reset (`reset`=0 at an edge):
  - Pointers = 0, `count` = 0, `overflow` = 0.
  - Resulting outputs: `empty`=1, `full`=0, `r_data`=0.
  - Array contents are not cleared and are don't-care.
  - Reset overrides `wr` and `rd` on the same edge.
  - A reset in the middle of a burst discards all stored bytes.

## Timing
- Write latency: for a push on edge k, `empty`=0, `count` and `r_data` are updated right after edge k. The byte can be popped at edge k+1.
- Pop: with `rd`=1 at edge k, the next byte (or 0 if the queue is now empty) appears on `r_data` right after edge k.
- Sustained throughput: 1 push and 1 pop per cycle.
- `rd` and `wr` are single-cycle pulses. Holding either high for N cycles performs N operations; consumers must pulse.
- No combinational path from `wr`/`rd` to `empty`, `full` or `count`. The only combinational output path is from the array and pointer to `r_data`.

## Test plan
- Reset, then idle 3 cycles → `empty`=1, `full`=0, `count`=0, `overflow`=0, `r_data`=0x00.
- Push 0x11 → `r_data`=0x11, `count`=1 after that edge. Pop → `empty`=1, `r_data`=0x00.
- Push 0xA1, 0xA2, 0xA3, 0xA4 → `full`=1, `count`=4. Push 0xA5 → dropped, `overflow`=1, `count`=4. Pop 4 times → 0xA1..0xA4 in order, then `empty`=1. `overflow` stays 1.
- Wrap-around: push 3, pop 3, then push 0x01..0x04 → pops return 0x01..0x04; pointers have wrapped with no corruption.
- Simultaneous `wr`/`rd`:
  - When empty, push 0x5A with `rd`=1 → `count`=1, `r_data`=0x5A.
  - When full (0xB1..0xB4), push 0xB5 with `rd`=1 → `count`=4, no overflow; the pop order is then 0xB2..0xB5.
- Reset mid-burst: after 2 stored bytes, hold `reset`=0 on an edge that also has `wr`=1 → `count`=0, `empty`=1, `overflow`=0, and the pushed byte is not stored.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: byte FIFO that sits between the UART receiver and its consumer,
// or ahead of the transmitter. The oldest stored word is shown on r_data
// without a pop (first-word fall-through).
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   reset     synchronous, active-low reset
//   wr        push request, one pulse per word
//   w_data    word to push, sampled on an edge where wr=1
//   rd        pop request, one pulse per word
//   r_data    head-of-queue word; reads as 0 while empty
//   empty     no words stored
//   full      2**ADDR_W words stored
//   count     number of stored words, 0 .. 2**ADDR_W
//   overflow  sticky: at least one push was dropped since reset
module uart_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              do_push;
    logic              do_pop;

    // Flags come from the registered count only, so wr/rd never reach them
    // combinationally.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A pop on an empty queue is ignored. When full, a push still succeeds if
    // a pop frees a slot on the same edge.
    assign do_pop  = rd && !empty;
    assign do_push = wr && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) w_ptr <= w_ptr + 1'b1;
            if (do_pop)  r_ptr <= r_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr && !do_push) overflow <= 1'b1;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (reset && do_push) mem[w_ptr] <= w_data;
    end

    assign r_data = empty ? '0 : mem[r_ptr];

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

    localparam int DBIT   = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr;
    logic [DBIT-1:0]   w_data;
    logic              rd;
    logic [DBIT-1:0]   r_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    logic [DBIT-1:0] q[$];   // scoreboard: expected stored words, head first
    logic            ovf_m;  // expected overflow flag

    uart_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .rd       (rd),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the scoreboard is updated with what the edge
    // should do. Outputs are sampled 1 time unit after the edge.
    task automatic op(input logic w, input logic [DBIT-1:0] d, input logic r,
                      input logic rst);
        bit popped;
        reset  = ~rst;
        wr     = w;
        w_data = d;
        rd     = r;
        popped = r && (q.size() > 0) && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (popped) void'(q.pop_front());
            if (w) begin
                if (q.size() < DEPTH) q.push_back(d);
                else ovf_m = 1'b1;
            end
        end
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic test_reset();
        op(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) op(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", r_data); end
    endtask

    task automatic test_single();
        op(1'b1, 8'h11, 1'b0, 1'b0);
        checks++; if (r_data !== 8'h11) begin errors++; $display("FAIL single_rdata got=%h exp=11", r_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", empty); end
        op(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL single_pop_rdata got=%h exp=00", r_data); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) op(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        op(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", count, q.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, r_data, exp); end
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got=%b exp=1", empty); end
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, ovf_m); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) op(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL wrap_pre%0d got=%h exp=%h", i, r_data, exp); end
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) op(1'b1, 8'h01 + 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got=%b exp=1", full); end
        for (int i = 0; i < 4; i++) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, r_data, exp); end
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simul();
        op(1'b0, 8'h00, 1'b0, 1'b1);
        op(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
        checks++; if (r_data !== 8'h5A) begin errors++; $display("FAIL simul_empty_rdata got=%h exp=5a", r_data); end
        op(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) op(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0);
        op(1'b1, 8'hB5, 1'b1, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_full_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_full_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL simul_pop%0d got=%h exp=%h", i, r_data, exp); end
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        op(1'b1, 8'h61, 1'b0, 1'b0);
        op(1'b1, 8'h62, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, r_data, exp); end
            op(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, count, q.size()); end
        end
        while (q.size() > 0) begin
            logic [DBIT-1:0] exp;
            exp = q[0];
            checks++; if (r_data !== exp) begin errors++; $display("FAIL b2b_drain got=%h exp=%h", r_data, exp); end
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 5; i++) op(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL mid_pre got=ovf%b/cnt%0d exp=ovf1/cnt2", overflow, count); end
        op(1'b1, 8'hC9, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL mid_rdata got=%h exp=00", r_data); end
        op(1'b1, 8'hD1, 1'b0, 1'b0);
        checks++; if (r_data !== 8'hD1 || count !== 3'd1) begin errors++; $display("FAIL mid_after got=%h/%0d exp=d1/1", r_data, count); end
    endtask

    initial begin
        reset  = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        ovf_m  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap();
        test_simul();
        test_back_to_back();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
